// File: rtl/bcd_pkg.sv
// Shared types and helpers for the 4-digit BCD event counter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } run_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Presets from software may hold A..F; force them back into decimal range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_count4_if.sv
// Control and digit bus between the BCD counter and its host/alarm/display logic.
interface bcd_count4_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  d3;
    logic        running;
    logic        tick_o;
    logic        limit_o;

    modport master (
        output start, stop, clear, up_dn, load, load_val,
        input  d0, d1, d2, d3, running, tick_o, limit_o
    );

    modport slave (
        input  start, stop, clear, up_dn, load, load_val,
        output d0, d1, d2, d3, running, tick_o, limit_o
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: loadable up/down 0..9 register with ripple carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up_dn,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       co
);

    assign co = en & (up_dn ? (q == BCD_MAX) : (q == 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= bcd_clamp(ld_val);
        end else if (en) begin
            if (up_dn)
                q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
            else
                q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_count4.sv
// 4-digit BCD up/down event counter: prescaler, run-control FSM, saturate
// detect and registered tick/limit pulses around a ripple chain of decades.
module bcd_count4
    import bcd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter bit WRAP    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    bcd_count4_if.slave  bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_div_check
            $error("bcd_count4: CLK_HZ/TICK_HZ must be >= 2");
        end
    endgenerate

    run_state_t  state;
    logic [CW-1:0] pre_cnt;
    logic        tick_int;
    logic        step;
    logic        at_limit;
    logic        sat_hit;
    logic        digit_en;
    logic        digit_ld;
    logic [15:0] ld_word;
    logic [3:0]  q [4];
    logic [3:0]  co;
    logic [3:0]  en_chain;
    logic        limit_next;

    assign tick_int = (state == RUN) && (pre_cnt == CW'(DIV - 1));
    // clear, load and stop all outrank a pending tick, which is then dropped
    assign step     = tick_int & ~(bus.clear | bus.load | bus.stop);

    assign at_limit = bus.up_dn
        ? ((q[0] == BCD_MAX) && (q[1] == BCD_MAX) && (q[2] == BCD_MAX) && (q[3] == BCD_MAX))
        : ((q[0] == 4'd0) && (q[1] == 4'd0) && (q[2] == 4'd0) && (q[3] == 4'd0));

    assign sat_hit    = step & at_limit & ~WRAP;
    assign digit_en   = step & ~sat_hit;
    assign limit_next = WRAP ? co[3] : sat_hit;

    assign digit_ld = bus.clear | bus.load;
    assign ld_word  = bus.clear ? 16'h0000 : bus.load_val;
    assign en_chain = {co[2:0], digit_en};

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .en     (en_chain[i]),
            .up_dn  (bus.up_dn),
            .ld     (digit_ld),
            .ld_val (ld_word[4*i +: 4]),
            .q      (q[i]),
            .co     (co[i])
        );
    end

    assign bus.d0 = q[0];
    assign bus.d1 = q[1];
    assign bus.d2 = q[2];
    assign bus.d3 = q[3];

    // state | meaning
    // IDLE  | cleared, waiting for start
    // RUN   | prescaler advancing, digits step on each tick
    // PAUSE | halted by stop or saturation, prescaler frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus.running <= 1'b0;
        end else if (bus.clear) begin
            state       <= IDLE;
            bus.running <= 1'b0;
        end else if (bus.load) begin
            state       <= state;
        end else if (bus.stop) begin
            if (state == RUN) begin
                state       <= PAUSE;
                bus.running <= 1'b0;
            end
        end else if (bus.start) begin
            state       <= RUN;
            bus.running <= 1'b1;
        end else if (sat_hit) begin
            state       <= PAUSE;
            bus.running <= 1'b0;
        end
    end

    // Resuming from PAUSE keeps the partial prescale so the next tick is not late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (bus.clear || bus.load) begin
            pre_cnt <= '0;
        end else if ((state == IDLE) && bus.start && !bus.stop) begin
            pre_cnt <= '0;
        end else if ((state == RUN) && !bus.stop) begin
            pre_cnt <= tick_int ? '0 : pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tick_o  <= 1'b0;
            bus.limit_o <= 1'b0;
        end else begin
            bus.tick_o  <= digit_en;
            bus.limit_o <= limit_next;
        end
    end

endmodule

// File: tb/tb_bcd_count4.sv
// Directed bench: a wrapping instance and a saturating instance, DIV = 10.
module tb_bcd_count4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_count4_if bus_w ();
    bcd_count4_if bus_s ();

    bcd_count4 #(.CLK_HZ(10), .TICK_HZ(1), .WRAP(1'b1)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    bcd_count4 #(.CLK_HZ(10), .TICK_HZ(1), .WRAP(1'b0)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] dig_w();
        return {bus_w.d3, bus_w.d2, bus_w.d1, bus_w.d0};
    endfunction

    function automatic logic [15:0] dig_s();
        return {bus_s.d3, bus_s.d2, bus_s.d1, bus_s.d0};
    endfunction

    task automatic wait_tick_w(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (bus_w.tick_o === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_limit_s(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (bus_s.limit_o === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic load_w(input logic [15:0] v);
        bus_w.load_val = v;
        bus_w.load = 1'b1;
        cyc();
        bus_w.load = 1'b0;
    endtask

    task automatic load_s(input logic [15:0] v);
        bus_s.load_val = v;
        bus_s.load = 1'b1;
        cyc();
        bus_s.load = 1'b0;
    endtask

    task automatic test_reset();
        bus_w.start = 0; bus_w.stop = 0; bus_w.clear = 0; bus_w.load = 0;
        bus_w.up_dn = 1; bus_w.load_val = 16'h0;
        bus_s.start = 0; bus_s.stop = 0; bus_s.clear = 0; bus_s.load = 0;
        bus_s.up_dn = 1; bus_s.load_val = 16'h0;
        rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({dig_w(), bus_w.running, bus_w.tick_o, bus_w.limit_o} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%b%b%b want 0000/000", dig_w(),
                     bus_w.running, bus_w.tick_o, bus_w.limit_o);
        end
        rst = 1'b0;
        repeat (2) cyc();
        checks++;
        if (dig_w() !== 16'h0000 || bus_w.running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %h run=%b want 0000 run=0", dig_w(), bus_w.running);
        end
    endtask

    task automatic test_first_tick();
        int n;
        bus_w.start = 1'b1;
        cyc();
        bus_w.start = 1'b0;
        checks++;
        if (bus_w.running !== 1'b1) begin
            errors++;
            $display("FAIL start_running got %b want 1", bus_w.running);
        end
        wait_tick_w(n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL first_tick_latency got %0d want 10", n);
        end
        checks++;
        if (dig_w() !== 16'h0001 || bus_w.limit_o !== 1'b0) begin
            errors++;
            $display("FAIL first_tick_digits got %h lim=%b want 0001 lim=0", dig_w(), bus_w.limit_o);
        end
    endtask

    task automatic test_carry();
        int n;
        load_w(16'h0009);
        checks++;
        if (dig_w() !== 16'h0009) begin
            errors++;
            $display("FAIL load_0009 got %h want 0009", dig_w());
        end
        wait_tick_w(n);
        checks++;
        if (n !== 10 || dig_w() !== 16'h0010) begin
            errors++;
            $display("FAIL carry_0010 got %h after %0d want 0010 after 10", dig_w(), n);
        end
        load_w(16'h0999);
        wait_tick_w(n);
        checks++;
        if (n !== 10 || dig_w() !== 16'h1000) begin
            errors++;
            $display("FAIL carry_1000 got %h after %0d want 1000 after 10", dig_w(), n);
        end
    endtask

    task automatic test_wrap();
        int n;
        load_w(16'h9999);
        wait_tick_w(n);
        checks++;
        if (n !== 10 || dig_w() !== 16'h0000 || bus_w.limit_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up got %h lim=%b n=%0d want 0000 lim=1 n=10", dig_w(), bus_w.limit_o, n);
        end
        bus_w.up_dn = 1'b0;
        wait_tick_w(n);
        checks++;
        if (n !== 10 || dig_w() !== 16'h9999 || bus_w.limit_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_down got %h lim=%b n=%0d want 9999 lim=1 n=10", dig_w(), bus_w.limit_o, n);
        end
        wait_tick_w(n);
        checks++;
        if (dig_w() !== 16'h9998 || bus_w.limit_o !== 1'b0) begin
            errors++;
            $display("FAIL down_step got %h lim=%b want 9998 lim=0", dig_w(), bus_w.limit_o);
        end
    endtask

    task automatic test_saturate();
        int n;
        load_s(16'h0000);
        bus_s.up_dn = 1'b0;
        bus_s.start = 1'b1;
        cyc();
        bus_s.start = 1'b0;
        wait_limit_s(n);
        checks++;
        if (n !== 10 || dig_s() !== 16'h0000 || bus_s.running !== 1'b0) begin
            errors++;
            $display("FAIL sat_down got %h run=%b n=%0d want 0000 run=0 n=10", dig_s(), bus_s.running, n);
        end
        load_s(16'h9999);
        bus_s.up_dn = 1'b1;
        bus_s.start = 1'b1;
        cyc();
        bus_s.start = 1'b0;
        wait_limit_s(n);
        checks++;
        if (n !== 10 || dig_s() !== 16'h9999 || bus_s.running !== 1'b0) begin
            errors++;
            $display("FAIL sat_up got %h run=%b n=%0d want 9999 run=0 n=10", dig_s(), bus_s.running, n);
        end
    endtask

    task automatic test_pause_resume();
        int n;
        int seen;
        bus_w.up_dn = 1'b1;
        load_w(16'h0100);
        repeat (3) cyc();
        bus_w.stop = 1'b1;
        cyc();
        bus_w.stop = 1'b0;
        checks++;
        if (bus_w.running !== 1'b0) begin
            errors++;
            $display("FAIL stop_running got %b want 0", bus_w.running);
        end
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (bus_w.tick_o === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || dig_w() !== 16'h0100) begin
            errors++;
            $display("FAIL pause_hold got %h ticks=%0d want 0100 ticks=0", dig_w(), seen);
        end
        bus_w.start = 1'b1;
        cyc();
        bus_w.start = 1'b0;
        wait_tick_w(n);
        checks++;
        if (n !== 7 || dig_w() !== 16'h0101) begin
            errors++;
            $display("FAIL resume_remaining got %h after %0d want 0101 after 7", dig_w(), n);
        end
    endtask

    task automatic test_edges();
        int seen;
        load_w(16'hFA3C);
        checks++;
        if (dig_w() !== 16'h9939) begin
            errors++;
            $display("FAIL load_clamp got %h want 9939", dig_w());
        end
        repeat (9) cyc();
        bus_w.clear = 1'b1;
        cyc();
        bus_w.clear = 1'b0;
        checks++;
        if (dig_w() !== 16'h0000 || bus_w.tick_o !== 1'b0 || bus_w.running !== 1'b0) begin
            errors++;
            $display("FAIL clear_on_tick got %h tick=%b run=%b want 0000 0 0", dig_w(),
                     bus_w.tick_o, bus_w.running);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (bus_w.tick_o === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || dig_w() !== 16'h0000) begin
            errors++;
            $display("FAIL idle_after_clear got %h ticks=%0d want 0000 ticks=0", dig_w(), seen);
        end
        bus_w.start = 1'b1;
        cyc();
        bus_w.start = 1'b0;
        repeat (9) cyc();
        load_w(16'h1234);
        checks++;
        if (dig_w() !== 16'h1234 || bus_w.tick_o !== 1'b0 || bus_w.running !== 1'b1) begin
            errors++;
            $display("FAIL load_on_tick got %h tick=%b run=%b want 1234 0 1", dig_w(),
                     bus_w.tick_o, bus_w.running);
        end
        repeat (3) cyc();
        rst = 1'b1;
        #2;
        checks++;
        if ({dig_w(), bus_w.running, bus_w.tick_o, bus_w.limit_o} !== 19'h0 ||
            dig_s() !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset got %h/%b%b%b sat=%h want 0000/000 sat=0000", dig_w(),
                     bus_w.running, bus_w.tick_o, bus_w.limit_o, dig_s());
        end
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_carry();
        test_wrap();
        test_saturate();
        test_pause_resume();
        test_edges();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
